// File: rtl/cp_inserter_if.sv
// Bus bundle for cp_inserter: IFFT sample input side and CP'd output side.
// master drives in_* and out_ready; slave (the inserter) drives out_* and overflow.
interface cp_inserter_if #(
  parameter int WIDTH  = 26,
  parameter int ADDR_W = 11
);
  logic              in_valid;
  logic [ADDR_W-1:0] in_addr;
  logic [WIDTH-1:0]  in_r;
  logic [WIDTH-1:0]  in_i;
  logic              out_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_r;
  logic [WIDTH-1:0]  out_i;
  logic              out_sop;
  logic              out_eop;
  logic              overflow;

  modport master (
    output in_valid, in_addr, in_r, in_i, out_ready,
    input  out_valid, out_r, out_i, out_sop, out_eop, overflow
  );

  modport slave (
    input  in_valid, in_addr, in_r, in_i, out_ready,
    output out_valid, out_r, out_i, out_sop, out_eop, overflow
  );
endinterface

// File: rtl/cp_inserter.sv
// Cyclic-prefix inserter: ping-pong N-sample banks filled by address, read as
// tail CP_LEN samples then the whole body; clk, rst (async low), bus (slave).
module cp_inserter #(
  parameter int WIDTH  = 26,
  parameter int N      = 1024,
  parameter int ADDR_W = 11,
  parameter int CP_LEN = 72
) (
  input logic          clk,
  input logic          rst,
  cp_inserter_if.slave bus
);

  localparam int AW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam int DW = 2 * WIDTH;

  localparam logic [AW-1:0]   CP_START = AW'(N - CP_LEN);
  localparam logic [AW-1:0]   A_LAST   = AW'(N - 1);
  localparam logic [ADDR_W:0] N_EXT    = (ADDR_W + 1)'(N);
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
  localparam bit              CP_ONE   = (CP_LEN == 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CP,
    S_BODY
  } state_t;

  logic [DW-1:0] mem [2*N];

  state_t        state_q, state_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          ovf_q, ovf_d;

  logic          p1_v_q, p1_v_d;
  logic          p1_sop_q, p1_sop_d;
  logic          p1_eop_q, p1_eop_d;
  logic [DW-1:0] p1_data_q;

  logic          out_v_q, out_v_d;
  logic          out_sop_q, out_sop_d;
  logic          out_eop_q, out_eop_d;
  logic [DW-1:0] out_data_q, out_data_d;

  logic          in_range;
  logic          wr_ok;
  logic          wr_done;
  logic [AW:0]   wr_idx;
  logic          nxt_full;

  logic          p1_go;
  logic          can_rd;
  logic          ren;
  logic          rsop;
  logic          reop;
  logic          rel;
  logic [AW-1:0] raddr;

  // Write side
  assign in_range = {1'b0, bus.in_addr} < N_EXT;
  assign wr_ok    = bus.in_valid && !full_q[wr_bank_q] && in_range;
  assign wr_done  = wr_ok && (wr_cnt_q == CNT_LAST);
  assign wr_idx   = {wr_bank_q, bus.in_addr[AW-1:0]};

  // Flag of the bank the reader moves to, as it will be after this edge
  assign nxt_full = full_q[~rd_bank_q]
                  || (wr_done && (wr_bank_q == ~rd_bank_q));

  // The read register holds its sample while the output register stalls,
  // so a read is issued only if that register will be free after the edge.
  assign p1_go  = !out_v_q || bus.out_ready;
  assign can_rd = !p1_v_q || p1_go;

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    ovf_d     = ovf_q;
    if (wr_ok) begin
      if (wr_done) begin
        wr_cnt_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + CW'(1);
      end
    end
    if (bus.in_valid && !wr_ok) begin
      ovf_d = 1'b1;
    end
  end

  // Read FSM; IDLE issues the first CP read itself to save a cycle
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_bank_d = rd_bank_q;
    ren       = 1'b0;
    rsop      = 1'b0;
    reop      = 1'b0;
    rel       = 1'b0;
    raddr     = rd_addr_q;
    unique case (state_q)
      S_IDLE: begin
        raddr = CP_START;
        if (full_q[rd_bank_q] && can_rd) begin
          ren  = 1'b1;
          rsop = 1'b1;
          if (CP_ONE) begin
            state_d   = S_BODY;
            rd_addr_d = '0;
          end else begin
            state_d   = S_CP;
            rd_addr_d = CP_START + AW'(1);
          end
        end
      end
      S_CP: begin
        if (can_rd) begin
          ren  = 1'b1;
          rsop = (rd_addr_q == CP_START);
          if (rd_addr_q == A_LAST) begin
            state_d   = S_BODY;
            rd_addr_d = '0;
          end else begin
            rd_addr_d = rd_addr_q + AW'(1);
          end
        end
      end
      S_BODY: begin
        if (can_rd) begin
          ren = 1'b1;
          if (rd_addr_q == A_LAST) begin
            reop      = 1'b1;
            rel       = 1'b1;
            rd_bank_d = ~rd_bank_q;
            if (nxt_full) begin
              state_d   = S_CP;
              rd_addr_d = CP_START;
            end else begin
              state_d   = S_IDLE;
              rd_addr_d = '0;
            end
          end else begin
            rd_addr_d = rd_addr_q + AW'(1);
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        rd_addr_d = '0;
      end
    endcase
  end

  // Release first, then set: a bank refilled on the release edge stays full
  always_comb begin
    full_d = full_q;
    if (rel) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (wr_done) begin
      full_d[wr_bank_q] = 1'b1;
    end
  end

  always_comb begin
    p1_v_d     = p1_v_q;
    p1_sop_d   = p1_sop_q;
    p1_eop_d   = p1_eop_q;
    out_v_d    = out_v_q;
    out_sop_d  = out_sop_q;
    out_eop_d  = out_eop_q;
    out_data_d = out_data_q;
    if (p1_go) begin
      out_v_d = p1_v_q;
      p1_v_d  = 1'b0;
      if (p1_v_q) begin
        out_data_d = p1_data_q;
        out_sop_d  = p1_sop_q;
        out_eop_d  = p1_eop_q;
      end
    end
    if (ren) begin
      p1_v_d   = 1'b1;
      p1_sop_d = rsop;
      p1_eop_d = reop;
    end
  end

  // Sample storage, not reset; writer and reader never share a bank
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_idx] <= {bus.in_r, bus.in_i};
    end
    if (ren) begin
      p1_data_q <= mem[{rd_bank_q, raddr}];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= '0;
      wr_cnt_q   <= '0;
      rd_addr_q  <= '0;
      ovf_q      <= 1'b0;
      p1_v_q     <= 1'b0;
      p1_sop_q   <= 1'b0;
      p1_eop_q   <= 1'b0;
      out_v_q    <= 1'b0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_addr_q  <= rd_addr_d;
      ovf_q      <= ovf_d;
      p1_v_q     <= p1_v_d;
      p1_sop_q   <= p1_sop_d;
      p1_eop_q   <= p1_eop_d;
      out_v_q    <= out_v_d;
      out_sop_q  <= out_sop_d;
      out_eop_q  <= out_eop_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.out_valid = out_v_q;
  assign bus.out_r     = out_data_q[DW-1:WIDTH];
  assign bus.out_i     = out_data_q[WIDTH-1:0];
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.overflow  = ovf_q;

endmodule
